vec_issue_ctrl: RTL and testbench

Vector instruction issue controller sitting between the instruction parser and the vector lane datapath. It accepts one decoded vector instruction at a time (opcode, vs1, vs2, vd, vector length) and holds it until a per-register scoreboard shows no RAW/WAW hazard. It then sequences the instruction through the lanes as a series of element-group beats, marks vd pending, and clears pending bits as lane writebacks retire.

---
 rtl/vec_pkg.sv | 27 ++
 rtl/vec_scoreboard.sv | 45 ++++
 rtl/vec_issue_ctrl.sv | 176 +++++++++++++++++
 tb/tb_vec_issue_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared types for the vector issue controller: opcode/register widths,
// FSM state encoding and the latched instruction record.
package vec_pkg;

  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned VREG_W     = 5;
  // Wide enough for any MAX_VL this block is built with; the top narrows
  // its arithmetic to the configured vector length width.
  localparam int unsigned VL_FIELD_W = 16;

  typedef logic [VREG_W-1:0] vreg_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    HAZARD,
    ISSUE
  } vec_state_t;

  typedef struct packed {
    logic [OPCODE_W-1:0]   opcode;
    vreg_idx_t             vs1;
    vreg_idx_t             vs2;
    vreg_idx_t             vd;
    logic [VL_FIELD_W-1:0] vl;
  } vec_instr_t;

endpackage

// File: rtl/vec_scoreboard.sv
// Per-register pending scoreboard: one bit per architectural vector
// register, a set port, a clear port and three combinational read ports.
// A set and a clear of the same bit in one cycle leaves the bit set.
module vec_scoreboard
  import vec_pkg::*;
#(
  parameter int unsigned NUM_VREGS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  vreg_idx_t            set_idx,
  input  logic                 clr_en,
  input  vreg_idx_t            clr_idx,
  input  vreg_idx_t            rd_idx0,
  input  vreg_idx_t            rd_idx1,
  input  vreg_idx_t            rd_idx2,
  output logic                 rd_pend0,
  output logic                 rd_pend1,
  output logic                 rd_pend2,
  output logic [NUM_VREGS-1:0] sb_o
);

  logic [NUM_VREGS-1:0] sb_q;
  logic [NUM_VREGS-1:0] sb_d;

  // Next scoreboard value: clear applied first so a same-cycle set wins
  always_comb begin
    sb_d = sb_q;
    if (clr_en) sb_d[clr_idx] = 1'b0;
    if (set_en) sb_d[set_idx] = 1'b1;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  assign rd_pend0 = sb_q[rd_idx0];
  assign rd_pend1 = sb_q[rd_idx1];
  assign rd_pend2 = sb_q[rd_idx2];
  assign sb_o     = sb_q;

endmodule

// File: rtl/vec_issue_ctrl.sv
// Vector issue controller: accepts one decoded instruction, waits out
// RAW/WAW hazards on the register scoreboard, then sequences it to the
// lanes as LANES-element beats.
// Optional feature macro: VEC_ISSUE_PERF_EN enables the stall counter.
module vec_issue_ctrl
  import vec_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned NUM_VREGS  = 32,
  parameter  int unsigned LANES      = 4,
  parameter  int unsigned MAX_VL     = 32,
  localparam int unsigned EIW        = $clog2(MAX_VL),
  localparam int unsigned VLW        = $clog2(MAX_VL + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid_i,
  output logic                instr_ready_o,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [VREG_W-1:0]   vs1_i,
  input  logic [VREG_W-1:0]   vs2_i,
  input  logic [VREG_W-1:0]   vd_i,
  input  logic [VLW-1:0]      vl_i,
  output logic                lane_valid_o,
  input  logic                lane_ready_i,
  output logic [OPCODE_W-1:0] lane_opcode_o,
  output logic [VREG_W-1:0]   lane_vs1_o,
  output logic [VREG_W-1:0]   lane_vs2_o,
  output logic [VREG_W-1:0]   lane_vd_o,
  output logic [EIW-1:0]      lane_elem_idx_o,
  output logic [LANES-1:0]    lane_elem_mask_o,
  output logic                lane_last_o,
  input  logic                wb_valid_i,
  input  logic [VREG_W-1:0]   wb_vd_i,
  input  logic                wb_last_i,
  output logic                busy_o,
  output logic [31:0]         stall_cycles_o
);

  // Parser word must be able to carry an opcode; vl must tile into beats
  if (DATA_WIDTH < OPCODE_W || (MAX_VL % LANES) != 0) begin : g_param_check
    $error("vec_issue_ctrl: illegal DATA_WIDTH/LANES/MAX_VL combination");
  end

  vec_state_t           state_q, state_d;
  vec_instr_t           instr_q, instr_d;
  logic [EIW-1:0]       elem_idx_q;
  logic [VLW-1:0]       vl_clamped;
  logic                 accept;
  logic                 sb_set;
  logic                 beat_fire;
  logic                 hazard;
  logic                 pend_vs1, pend_vs2, pend_vd;
  logic [NUM_VREGS-1:0] sb_vec;
  logic [LANES-1:0]     mask_raw;
  logic                 last_raw;

  assign vl_clamped = (vl_i > VLW'(MAX_VL)) ? VLW'(MAX_VL) : vl_i;

  always_comb begin
    instr_d        = '0;
    instr_d.opcode = opcode_i;
    instr_d.vs1    = vs1_i;
    instr_d.vs2    = vs2_i;
    instr_d.vd     = vd_i;
    instr_d.vl     = VL_FIELD_W'(vl_clamped);
  end

  vec_scoreboard #(
    .NUM_VREGS (NUM_VREGS)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (sb_set),
    .set_idx  (instr_q.vd),
    .clr_en   (wb_valid_i & wb_last_i),
    .clr_idx  (wb_vd_i),
    .rd_idx0  (instr_q.vs1),
    .rd_idx1  (instr_q.vs2),
    .rd_idx2  (instr_q.vd),
    .rd_pend0 (pend_vs1),
    .rd_pend1 (pend_vs2),
    .rd_pend2 (pend_vd),
    .sb_o     (sb_vec)
  );

  assign hazard = pend_vs1 | pend_vs2 | pend_vd;

  // Beat shape from the current element index and latched vl
  always_comb begin
    mask_raw = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      mask_raw[k] = (VL_FIELD_W'(elem_idx_q) + VL_FIELD_W'(k)) < instr_q.vl;
    end
    last_raw = (VL_FIELD_W'(elem_idx_q) + VL_FIELD_W'(LANES)) >= instr_q.vl;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state and handshake outputs
  always_comb begin
    state_d       = state_q;
    instr_ready_o = 1'b0;
    lane_valid_o  = 1'b0;
    accept        = 1'b0;
    sb_set        = 1'b0;
    beat_fire     = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) begin
          accept = 1'b1;
          // vl == 0 retires on acceptance without touching the lanes
          if (vl_clamped != '0) state_d = HAZARD;
        end
      end
      HAZARD: begin
        if (!hazard) begin
          sb_set  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lane_valid_o = 1'b1;
        if (lane_ready_i) begin
          beat_fire = 1'b1;
          if (last_raw) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latched instruction and element index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      elem_idx_q <= '0;
    end else begin
      if (accept) instr_q <= instr_d;
      if (sb_set)         elem_idx_q <= '0;
      else if (beat_fire) elem_idx_q <= elem_idx_q + EIW'(LANES);
    end
  end

  assign lane_opcode_o    = instr_q.opcode;
  assign lane_vs1_o       = instr_q.vs1;
  assign lane_vs2_o       = instr_q.vs2;
  assign lane_vd_o        = instr_q.vd;
  assign lane_elem_idx_o  = elem_idx_q;
  assign lane_elem_mask_o = (state_q == ISSUE) ? mask_raw : '0;
  assign lane_last_o      = (state_q == ISSUE) & last_raw;
  assign busy_o           = (state_q != IDLE) | (|sb_vec);

`ifdef VEC_ISSUE_PERF_EN
  logic [31:0] stall_q;
  logic        stall_evt;

  assign stall_evt = (state_q == HAZARD) | (lane_valid_o & ~lane_ready_i);

  // Saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          stall_q <= '0;
    else if (stall_evt && stall_q != '1) stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Directed self-checking bench for vec_issue_ctrl (default parameters).
module tb_vec_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [6:0]  opcode_i = '0;
  logic [4:0]  vs1_i = '0, vs2_i = '0, vd_i = '0;
  logic [5:0]  vl_i = '0;
  logic        lane_valid_o;
  logic        lane_ready_i = 1'b1;
  logic [6:0]  lane_opcode_o;
  logic [4:0]  lane_vs1_o, lane_vs2_o, lane_vd_o;
  logic [4:0]  lane_elem_idx_o;
  logic [3:0]  lane_elem_mask_o;
  logic        lane_last_o;
  logic        wb_valid_i = 1'b0;
  logic [4:0]  wb_vd_i = '0;
  logic        wb_last_i = 1'b0;
  logic        busy_o;
  logic [31:0] stall_cycles_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vec_issue_ctrl #(
    .DATA_WIDTH (32),
    .NUM_VREGS  (32),
    .LANES      (4),
    .MAX_VL     (32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr_valid_i    (instr_valid_i),
    .instr_ready_o    (instr_ready_o),
    .opcode_i         (opcode_i),
    .vs1_i            (vs1_i),
    .vs2_i            (vs2_i),
    .vd_i             (vd_i),
    .vl_i             (vl_i),
    .lane_valid_o     (lane_valid_o),
    .lane_ready_i     (lane_ready_i),
    .lane_opcode_o    (lane_opcode_o),
    .lane_vs1_o       (lane_vs1_o),
    .lane_vs2_o       (lane_vs2_o),
    .lane_vd_o        (lane_vd_o),
    .lane_elem_idx_o  (lane_elem_idx_o),
    .lane_elem_mask_o (lane_elem_mask_o),
    .lane_last_o      (lane_last_o),
    .wb_valid_i       (wb_valid_i),
    .wb_vd_i          (wb_vd_i),
    .wb_last_i        (wb_last_i),
    .busy_o           (busy_o),
    .stall_cycles_o   (stall_cycles_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] d, input logic [5:0] vl);
    opcode_i = op; vs1_i = s1; vs2_i = s2; vd_i = d; vl_i = vl;
    instr_valid_i = 1'b1;
    tick();
    instr_valid_i = 1'b0;
  endtask

  task automatic wb_pulse(input logic [4:0] d, input logic last);
    wb_valid_i = 1'b1; wb_vd_i = d; wb_last_i = last;
    tick();
    wb_valid_i = 1'b0; wb_last_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          exp_idx [3];
    int          exp_mask[3];
    int          exp_last[3];
    logic [31:0] base;
    int          beats;
    int          last_idx;
    int          last_mask;
    bit          done;

    exp_idx  = '{0, 4, 8};
    exp_mask = '{4'hF, 4'hF, 4'h3};
    exp_last = '{0, 0, 1};

    // Reset values
    tick(); tick();
    check_eq("rst_ready", instr_ready_o, 1);
    check_eq("rst_valid", lane_valid_o, 0);
    check_eq("rst_last",  lane_last_o, 0);
    check_eq("rst_busy",  busy_o, 0);
    check_eq("rst_stall", stall_cycles_o, 0);
    check_eq("rst_fields", {lane_opcode_o, lane_vs1_o, lane_vs2_o, lane_vd_o,
                            lane_elem_idx_o, lane_elem_mask_o}, 0);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_ready", instr_ready_o, 1);

    // vl=10 over three beats, no hazards
    send(7'h15, 5'd1, 5'd2, 5'd5, 6'd10);
    check_eq("t1_hz_valid", lane_valid_o, 0);
    check_eq("t1_hz_ready", instr_ready_o, 0);
    check_eq("t1_hz_busy",  busy_o, 1);
    tick();
    for (int b = 0; b < 3; b++) begin
      check_eq($sformatf("t1_valid%0d", b), lane_valid_o, 1);
      check_eq($sformatf("t1_idx%0d",   b), lane_elem_idx_o, exp_idx[b]);
      check_eq($sformatf("t1_mask%0d",  b), lane_elem_mask_o, exp_mask[b]);
      check_eq($sformatf("t1_last%0d",  b), lane_last_o, exp_last[b]);
      check_eq($sformatf("t1_op%0d",    b), lane_opcode_o, 7'h15);
      check_eq($sformatf("t1_vd%0d",    b), lane_vd_o, 5);
      tick();
    end
    check_eq("t1_done_valid", lane_valid_o, 0);
    check_eq("t1_done_ready", instr_ready_o, 1);
    check_eq("t1_sb_busy",    busy_o, 1);
    wb_pulse(5'd5, 1'b0);
    check_eq("t1_mid_wb_busy", busy_o, 1);
    wb_pulse(5'd5, 1'b1);
    check_eq("t1_clr_busy", busy_o, 0);

    // RAW hazard: B reads v3 while A's write to v3 is pending
    send(7'h01, 5'd0, 5'd0, 5'd3, 6'd4);
    tick();
    check_eq("t2_a_valid", lane_valid_o, 1);
    check_eq("t2_a_last",  lane_last_o, 1);
    tick();
    send(7'h02, 5'd3, 5'd4, 5'd6, 6'd4);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t2_hold%0d", i), lane_valid_o, 0);
      tick();
    end
    wb_valid_i = 1'b1; wb_vd_i = 5'd3; wb_last_i = 1'b1;
    tick();
    wb_valid_i = 1'b0; wb_last_i = 1'b0;
    check_eq("t2_rel_plus1", lane_valid_o, 0);
    tick();
    check_eq("t2_rel_plus2", lane_valid_o, 1);
    check_eq("t2_b_vs1",     lane_vs1_o, 3);
    check_eq("t2_b_mask",    lane_elem_mask_o, 4'hF);
    tick();
    wb_pulse(5'd6, 1'b1);
    check_eq("t2_clr_busy", busy_o, 0);

    // vl=0 retires on acceptance
    send(7'h03, 5'd1, 5'd1, 5'd9, 6'd0);
    check_eq("t3_ready", instr_ready_o, 1);
    check_eq("t3_valid", lane_valid_o, 0);
    check_eq("t3_busy",  busy_o, 0);
    tick();
    check_eq("t3_valid2", lane_valid_o, 0);
    check_eq("t3_busy2",  busy_o, 0);

    // Lane back-pressure for 5 cycles on beat 2 of 3
    send(7'h04, 5'd1, 5'd2, 5'd10, 6'd12);
    tick();
    tick();
    check_eq("t4_b1_idx", lane_elem_idx_o, 4);
    base = stall_cycles_o;
    lane_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("t4_valid%0d", i), lane_valid_o, 1);
      check_eq($sformatf("t4_idx%0d",   i), lane_elem_idx_o, 4);
      check_eq($sformatf("t4_mask%0d",  i), lane_elem_mask_o, 4'hF);
      check_eq($sformatf("t4_last%0d",  i), lane_last_o, 0);
      check_eq($sformatf("t4_op%0d",    i), lane_opcode_o, 7'h04);
    end
`ifdef VEC_ISSUE_PERF_EN
    check_eq("t4_stall", stall_cycles_o, base + 32'd5);
`else
    check_eq("t4_stall", stall_cycles_o, 0);
`endif
    lane_ready_i = 1'b1;
    tick();
    check_eq("t4_b2_idx",  lane_elem_idx_o, 8);
    check_eq("t4_b2_last", lane_last_o, 1);
    tick();
    wb_pulse(5'd10, 1'b1);
    check_eq("t4_clr_busy", busy_o, 0);

    // Same-cycle set and clear of v7: set wins
    send(7'h05, 5'd0, 5'd0, 5'd7, 6'd4);
    wb_valid_i = 1'b1; wb_vd_i = 5'd7; wb_last_i = 1'b1;
    tick();
    wb_valid_i = 1'b0; wb_last_i = 1'b0;
    check_eq("t5_valid", lane_valid_o, 1);
    tick();
    check_eq("t5_sb7_busy", busy_o, 1);
    wb_pulse(5'd7, 1'b1);
    check_eq("t5_clr_busy", busy_o, 0);

    // vl above MAX_VL clamps to 32 elements: 8 beats
    send(7'h06, 5'd0, 5'd0, 5'd11, 6'd40);
    beats = 0; last_idx = -1; last_mask = -1; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (lane_valid_o) begin
        beats++;
        if (lane_last_o) begin
          last_idx  = int'(lane_elem_idx_o);
          last_mask = int'(lane_elem_mask_o);
          done      = 1'b1;
        end
      end
      tick();
    end
    check_eq("t6_beats",     beats, 8);
    check_eq("t6_last_idx",  last_idx, 28);
    check_eq("t6_last_mask", last_mask, 4'hF);
    check_eq("t6_idle",      instr_ready_o, 1);
    wb_pulse(5'd11, 1'b1);

    // Reset during beat 2 of 3
    send(7'h07, 5'd1, 5'd2, 5'd12, 6'd12);
    tick();
    tick();
    check_eq("t7_pre_valid", lane_valid_o, 1);
    check_eq("t7_pre_idx",   lane_elem_idx_o, 4);
    rst_n = 1'b0;
    #1;
    check_eq("t7_rst_valid", lane_valid_o, 0);
    check_eq("t7_rst_busy",  busy_o, 0);
    check_eq("t7_rst_last",  lane_last_o, 0);
    check_eq("t7_rst_vd",    lane_vd_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("t7_rel_ready", instr_ready_o, 1);
    check_eq("t7_rel_busy",  busy_o, 0);
    check_eq("t7_rel_stall", stall_cycles_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
